ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 104 ++++++++++
 tb/tb_ps2_host_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter with glitch-filtered line sampling,
// device ACK check and inter-edge watchdog.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int SETUP_CYCLES = 100,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  output logic       timeout,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);
  typedef enum logic [2:0] {IDLE, INHIBIT, SETUP, SEND, ACK, WAIT_IDLE} state_t;
  state_t state, stateNext;
  logic [7:0] clkSr, dataSr;
  logic clkF, dataF, clkPrev;
  logic [10:0] sh, shNext;
  logic [3:0] bitCnt, bitCntNext;
  logic [31:0] cnt, cntNext;
  logic fall, edgeSeen;
  assign fall = clkPrev & ~clkF;
  assign edgeSeen = clkPrev ^ clkF;
  assign tx_ready = state == IDLE;
  assign busy = state != IDLE;
  assign ps2_clk_oe = state == INHIBIT || state == SETUP;
  // sh[0] is the bit currently on the wire: start bit first, stop bit last
  assign ps2_data_oe = (state == SETUP || state == SEND) && !sh[0];
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      clkSr <= '1;
      dataSr <= '1;
      clkF <= 1'b1;
      dataF <= 1'b1;
      clkPrev <= 1'b1;
      state <= IDLE;
      sh <= '0;
      bitCnt <= '0;
      cnt <= '0;
    end else begin
      clkSr <= {clkSr[6:0], ps2_clk_in};
      dataSr <= {dataSr[6:0], ps2_data_in};
      clkF <= &clkSr ? 1'b1 : (|clkSr ? clkF : 1'b0);
      dataF <= &dataSr ? 1'b1 : (|dataSr ? dataF : 1'b0);
      clkPrev <= clkF;
      state <= stateNext;
      sh <= shNext;
      bitCnt <= bitCntNext;
      cnt <= cntNext;
    end
  end
  always_comb begin
    stateNext = state;
    shNext = sh;
    bitCntNext = bitCnt;
    cntNext = cnt + 32'd1;
    done = 1'b0;
    ack_error = 1'b0;
    timeout = 1'b0;
    case (state)
      IDLE: begin
        cntNext = '0;
        if (tx_valid) begin
          shNext = {1'b1, ~^tx_data, tx_data, 1'b0};
          bitCntNext = '0;
          stateNext = INHIBIT;
        end
      end
      INHIBIT: if (cnt == INHIBIT_CYCLES - 1) begin
        cntNext = '0;
        stateNext = SETUP;
      end
      SETUP: if (cnt == SETUP_CYCLES - 1) begin
        cntNext = '0;
        stateNext = SEND;
      end
      default: begin
        if (edgeSeen) cntNext = '0;
        if (state == SEND && fall) begin
          shNext = {1'b1, sh[10:1]};
          bitCntNext = bitCnt + 4'd1;
          stateNext = bitCnt == 4'd9 ? ACK : SEND;
        end else if (state == ACK && fall) begin
          ack_error = dataF;
          stateNext = dataF ? IDLE : WAIT_IDLE;
        end else if (state == WAIT_IDLE && clkF && dataF) begin
          done = 1'b1;
          stateNext = IDLE;
        end else if (!edgeSeen && cnt == TIMEOUT_CYCLES - 1) begin
          timeout = 1'b1;
          stateNext = IDLE;
        end
      end
    endcase
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed vectors against a behavioural PS/2 device that clocks
// the frame in, samples on rising edges and drives the ACK.
module tb_ps2_host_tx;
  localparam int INH = 20, SET = 5, TO = 400, H = 30;
  logic clk = 1'b0, clr_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic tx_valid = 1'b0;
  logic tx_ready, busy, done, ack_error, timeout, ps2_clk_oe, ps2_data_oe;
  logic devClk = 1'b1, devData = 1'b1;
  logic ps2_clk_in, ps2_data_in;
  int total = 0, bad = 0;
  int doneCnt = 0, errCnt = 0, toCnt = 0, inhCnt = 0, setCnt = 0, accCnt = 0;
  assign ps2_clk_in = devClk & ~ps2_clk_oe;
  assign ps2_data_in = devData & ~ps2_data_oe;
  always #5 clk = ~clk;
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .SETUP_CYCLES(SET), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .clr_n(clr_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .ack_error(ack_error), .timeout(timeout),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );
  always @(negedge clk) begin
    if (done) doneCnt++;
    if (ack_error) errCnt++;
    if (timeout) toCnt++;
    if (ps2_clk_oe && !ps2_data_oe) inhCnt++;
    if (ps2_clk_oe && ps2_data_oe) setCnt++;
  end
  always @(posedge clk) if (tx_valid && tx_ready) accCnt++;

  typedef struct {
    logic [7:0] data;
    bit ackHigh;
    bit glitch;
    bit par;
    bit expDone;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic device(input bit ackHigh, input bit glitch, output logic [10:0] got, output bit ok);
    int n;
    n = 0;
    ok = 1'b1;
    got = '0;
    while (ps2_clk_oe !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    while (ps2_clk_oe !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
    if (ps2_clk_oe !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    repeat (H) @(negedge clk);
    got[0] = ps2_data_in;
    for (int k = 1; k <= 10; k++) begin
      devClk = 1'b0;
      repeat (H) @(negedge clk);
      devClk = 1'b1;
      got[k] = ps2_data_in;
      if (glitch && k == 4) begin
        repeat (10) @(negedge clk);
        devClk = 1'b0;
        repeat (3) @(negedge clk);
        devClk = 1'b1;
        repeat (H - 13) @(negedge clk);
      end else repeat (H) @(negedge clk);
    end
    devData = ackHigh;
    repeat (15) @(negedge clk);
    devClk = 1'b0;
    repeat (H) @(negedge clk);
    devClk = 1'b1;
    repeat (5) @(negedge clk);
    devData = 1'b1;
    n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    if (busy) ok = 1'b0;
  endtask

  task automatic runVec(input vec_t v);
    int d0, e0, t0, i0, s0;
    logic [10:0] got;
    bit ok;
    d0 = doneCnt; e0 = errCnt; t0 = toCnt; i0 = inhCnt; s0 = setCnt;
    @(negedge clk);
    tx_data = v.data;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    check("ready_while_busy", tx_ready, 0);
    tx_data = ~v.data;
    device(v.ackHigh, v.glitch, got, ok);
    check("device_ok", ok, 1);
    check("start_bit", got[0], 0);
    check("data_byte", got[8:1], v.data);
    check("parity_bit", got[9], v.par);
    check("stop_bit", got[10], 1);
    check("inhibit_len", inhCnt - i0, INH);
    check("setup_len", setCnt - s0, SET);
    check("done_pulses", doneCnt - d0, v.expDone);
    check("ack_err_pulses", errCnt - e0, !v.expDone);
    check("timeout_pulses", toCnt - t0, 0);
    check("oe_released", {ps2_clk_oe, ps2_data_oe}, 0);
    check("ready_after", tx_ready, 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [10:0] got;
    bit ok;
    int n, d0, e0, t0, a0;
    vecs[0] = '{8'hED, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'hF4, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'hAA, 1'b0, 1'b1, 1'b1, 1'b1};
    repeat (3) @(negedge clk);
    check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    check("rst_busy", busy, 0);
    check("rst_status", {done, ack_error, timeout}, 0);
    clr_n = 1'b1;
    @(negedge clk);
    check("rst_ready", tx_ready, 1);
    for (int i = 0; i < 6; i++) runVec(vecs[i]);

    // held request: second byte waits for the first frame to finish
    a0 = accCnt; d0 = doneCnt;
    @(negedge clk);
    tx_data = 8'hF4;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h55;
    device(1'b0, 1'b0, got, ok);
    check("hold_dev_ok", ok, 1);
    check("hold_first_byte", got[8:1], 8'hF4);
    check("hold_accepts_during", accCnt - a0, 1);
    check("hold_done_first", doneCnt - d0, 1);
    @(negedge clk);
    check("hold_accepts_after", accCnt - a0, 2);
    check("hold_busy_again", busy, 1);
    tx_valid = 1'b0;
    device(1'b0, 1'b0, got, ok);
    check("hold_second_byte", got[8:1], 8'h55);
    check("hold_done_second", doneCnt - d0, 2);

    // no device clocks: watchdog must fire
    t0 = toCnt; d0 = doneCnt; e0 = errCnt;
    @(negedge clk);
    tx_data = 8'hFF;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while (ps2_clk_oe !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    n = 0;
    while (!timeout && n < TO + 100) begin @(negedge clk); n++; end
    total++;
    if (n < TO || n > TO + 12) begin
      bad++;
      $display("FAIL timeout_latency: got %0d cycles want %0d..%0d", n, TO, TO + 12);
    end
    @(negedge clk);
    check("to_oe_released", {ps2_clk_oe, ps2_data_oe}, 0);
    check("to_ready", tx_ready, 1);
    check("to_pulses", toCnt - t0, 1);
    check("to_no_other", (doneCnt - d0) + (errCnt - e0), 0);

    // asynchronous reset in the middle of the data bits
    d0 = doneCnt; e0 = errCnt; t0 = toCnt;
    @(negedge clk);
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while (ps2_clk_oe !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    repeat (H) @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      devClk = 1'b0;
      repeat (H) @(negedge clk);
      devClk = 1'b1;
      repeat (H / 2) @(negedge clk);
    end
    check("mid_busy", busy, 1);
    #2 clr_n = 1'b0;
    #1;
    check("rst_mid_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    check("rst_mid_busy", busy, 0);
    repeat (3) @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", tx_ready, 1);
    check("rst_mid_no_status", (doneCnt - d0) + (errCnt - e0) + (toCnt - t0), 0);
    runVec('{8'h5A, 1'b0, 1'b0, 1'b1, 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
